ras_ckpt: RTL



---
 rtl/ras_ckpt.sv | 107 ++++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
`default_nettype none
// ============================================================================
//  Module   : ras_ckpt
//  Purpose  : Circular return address stack with saturating occupancy count.
//             Pointer and count are exported for per-prediction checkpointing
//             and can be restored in a single cycle. Supports any depth >= 2,
//             push, pop, replace-top (push+pop) and checkpoint restore.
//  Revision : 1.0  initial release
// ============================================================================
module ras_ckpt #(
  parameter int RAS_ENTRIES = 16,
  parameter int PC_WIDTH    = 38,
  parameter int IDX_WIDTH   = $clog2(RAS_ENTRIES),
  parameter int CNT_WIDTH   = $clog2(RAS_ENTRIES + 1)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 push_valid,
  input  logic [PC_WIDTH-1:0]  push_pc,
  input  logic                 pop_valid,
  output logic [PC_WIDTH-1:0]  top_pc,
  output logic                 top_valid,
  output logic [IDX_WIDTH-1:0] ras_idx,
  output logic [CNT_WIDTH-1:0] ras_count,
  input  logic                 restore_valid,
  input  logic [IDX_WIDTH-1:0] restore_idx,
  input  logic [CNT_WIDTH-1:0] restore_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RAS_ENTRIES - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(RAS_ENTRIES);

  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0] ptr_inc, ptr_dec;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [PC_WIDTH-1:0]  stack_q [RAS_ENTRIES];
  logic [PC_WIDTH-1:0]  stack_d [RAS_ENTRIES];
  logic                 wr_en;
  logic [IDX_WIDTH-1:0] wr_idx;

  // Explicit wrap-around neighbours of the top pointer (depth need not be 2^n)
  always_comb begin
    ptr_inc = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_WIDTH'(1);
    ptr_dec = (ptr_q == '0) ? LAST_IDX : ptr_q - IDX_WIDTH'(1);
  end

  // Next-state: restore > push&pop > push > pop > hold
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (restore_valid) begin
      // Stack contents are left alone; only the view into them is rewound
      ptr_d   = restore_idx;
      count_d = (restore_count > FULL_CNT) ? FULL_CNT : restore_count;
    end else if (push_valid && pop_valid) begin
      // Replace-top: the popped value is the current top, overwritten in place
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      count_d = (count_q == '0) ? CNT_WIDTH'(1) : count_q;
    end else if (push_valid) begin
      // When full, this silently overwrites the oldest entry
      wr_en   = 1'b1;
      wr_idx  = ptr_inc;
      ptr_d   = ptr_inc;
      count_d = (count_q == FULL_CNT) ? FULL_CNT : count_q + CNT_WIDTH'(1);
    end else if (pop_valid) begin
      // Pop on empty still walks the pointer; count floors at zero
      ptr_d   = ptr_dec;
      count_d = (count_q == '0) ? '0 : count_q - CNT_WIDTH'(1);
    end
  end

  // Stack array next value: at most one entry written per cycle
  always_comb begin
    stack_d = stack_q;
    if (wr_en) begin
      stack_d[wr_idx] = push_pc;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      stack_q <= stack_d;
    end
  end

  // Outputs are pure functions of the registered state
  always_comb begin
    top_pc    = stack_q[ptr_q];
    top_valid = (count_q != '0);
    ras_idx   = ptr_q;
    ras_count = count_q;
  end

endmodule
`default_nettype wire
